// File: rtl/axi_slave_mem_responder.sv
// AXI4 slave responder backed by a word-addressed internal memory.
// Independent write and read FSMs, one outstanding burst per direction.
module axi_slave_mem_responder #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 256,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                        ACLK,
    input  logic                        ARESET,
    input  logic [AXI_ID_WIDTH-1:0]     S_AWID,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_AWADDR,
    input  logic [3:0]                  S_AWLEN,
    input  logic [2:0]                  S_AWSIZE,
    input  logic [1:0]                  S_AWBURST,
    input  logic                        S_AWVALID,
    output logic                        S_AWREADY,
    input  logic [AXI_DATA_WIDTH-1:0]   S_WDATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] S_WSTRB,
    input  logic                        S_WLAST,
    input  logic                        S_WVALID,
    output logic                        S_WREADY,
    output logic [AXI_ID_WIDTH-1:0]     S_BID,
    output logic [1:0]                  S_BRESP,
    output logic                        S_BVALID,
    input  logic                        S_BREADY,
    input  logic [AXI_ID_WIDTH-1:0]     S_ARID,
    input  logic [AXI_ADDR_WIDTH-1:0]   S_ARADDR,
    input  logic [3:0]                  S_ARLEN,
    input  logic [2:0]                  S_ARSIZE,
    input  logic [1:0]                  S_ARBURST,
    input  logic                        S_ARVALID,
    output logic                        S_ARREADY,
    output logic [AXI_ID_WIDTH-1:0]     S_RID,
    output logic [AXI_DATA_WIDTH-1:0]   S_RDATA,
    output logic [1:0]                  S_RRESP,
    output logic                        S_RLAST,
    output logic                        S_RVALID,
    input  logic                        S_RREADY
);
    localparam int AW        = AXI_ADDR_WIDTH;
    localparam int DW        = AXI_DATA_WIDTH;
    localparam int SW        = DW / 8;
    localparam int ADDR_LSB  = $clog2(SW);
    localparam int IDX_W     = $clog2(MEM_DEPTH);
    localparam int MEM_BYTES = MEM_DEPTH * SW;
    // One extra bit so a window ending at the top of the address space does not wrap.
    localparam logic [AW:0] LIMIT = {1'b0, BASE_ADDR} + (AW+1)'(MEM_BYTES);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic in_range(input logic [AW-1:0] a);
        return (a >= BASE_ADDR) && ({1'b0, a} < LIMIT);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
        logic [AW-1:0] off;
        off = a - BASE_ADDR;
        return off[ADDR_LSB +: IDX_W];
    endfunction

    function automatic logic burst_err(input logic [3:0] len, input logic [2:0] size,
                                       input logic [1:0] burst);
        return (size > 3'(ADDR_LSB)) || (burst == 2'b11) ||
               ((burst == 2'b10) && !(len inside {4'd1, 4'd3, 4'd7, 4'd15}));
    endfunction

    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [3:0] len,
                                                input logic [2:0] size, input logic [1:0] burst);
        logic [AW-1:0] step, mask;
        step = AW'(1) << size;
        mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
        case (burst)
            2'b00:   next_addr = a;
            2'b10:   next_addr = (a & ~mask) | ((a + step) & mask);
            default: next_addr = a + step;
        endcase
    endfunction

    logic [DW-1:0] mem_q [MEM_DEPTH];

    // ---------------- write path ----------------
    wstate_t           w_state_q;
    logic              awready_q, wready_q, bvalid_q;
    logic [AXI_ID_WIDTH-1:0] bid_q;
    logic [1:0]        bresp_q;
    logic [AW-1:0]     waddr_q;
    logic [3:0]        wlen_q, wbeat_q;
    logic [2:0]        wsize_q;
    logic [1:0]        wburst_q;
    logic              wberr_q, wdec_q, wslv_q;
    logic              w_hs, w_inr, w_we, w_last, w_dec_d, w_slv_d;

    always_comb begin
        w_hs    = (w_state_q == W_DATA) && wready_q && S_WVALID;
        w_inr   = in_range(waddr_q);
        w_we    = w_hs && w_inr && !wberr_q;
        w_last  = (wbeat_q == wlen_q);
        w_dec_d = wdec_q | !w_inr;
        w_slv_d = wslv_q | (S_WLAST != w_last);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= 2'b00;
            wbeat_q   <= '0;
            wdec_q    <= 1'b0;
            wslv_q    <= 1'b0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (awready_q && S_AWVALID) begin
                        bid_q     <= S_AWID;
                        waddr_q   <= S_AWADDR;
                        wlen_q    <= S_AWLEN;
                        wsize_q   <= S_AWSIZE;
                        wburst_q  <= S_AWBURST;
                        wbeat_q   <= '0;
                        wdec_q    <= 1'b0;
                        wberr_q   <= burst_err(S_AWLEN, S_AWSIZE, S_AWBURST);
                        wslv_q    <= burst_err(S_AWLEN, S_AWSIZE, S_AWBURST);
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state_q <= W_DATA;
                    end else begin
                        awready_q <= 1'b1;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        wdec_q <= w_dec_d;
                        wslv_q <= w_slv_d;
                        if (w_last) begin
                            wready_q  <= 1'b0;
                            bvalid_q  <= 1'b1;
                            bresp_q   <= w_dec_d ? 2'b11 : (w_slv_d ? 2'b10 : 2'b00);
                            w_state_q <= W_RESP;
                        end else begin
                            wbeat_q <= wbeat_q + 4'd1;
                            waddr_q <= next_addr(waddr_q, wlen_q, wsize_q, wburst_q);
                        end
                    end
                end
                W_RESP: begin
                    if (S_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state_q <= W_IDLE;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge ACLK) begin
        if (w_we) begin
            for (int b = 0; b < SW; b++)
                if (S_WSTRB[b]) mem_q[word_idx(waddr_q)][8*b +: 8] <= S_WDATA[8*b +: 8];
        end
    end

    // ---------------- read path ----------------
    rstate_t           r_state_q;
    logic              arready_q, rvalid_q, rlast_q, rberr_q;
    logic [AXI_ID_WIDTH-1:0] rid_q;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [AW-1:0]     raddr_q, r_ld_addr;
    logic [3:0]        rlen_q, rbeat_q;
    logic [2:0]        rsize_q;
    logic [1:0]        rburst_q;
    logic              r_ld_berr, r_inr;

    // Beat 0 is loaded straight from the AR channel, later beats from the burst registers.
    always_comb begin
        r_ld_addr = (r_state_q == R_IDLE) ? S_ARADDR : raddr_q;
        r_ld_berr = (r_state_q == R_IDLE) ? burst_err(S_ARLEN, S_ARSIZE, S_ARBURST) : rberr_q;
        r_inr     = in_range(r_ld_addr);
        rdata_d   = (r_inr && !r_ld_berr) ? mem_q[word_idx(r_ld_addr)] : '0;
        rresp_d   = !r_inr ? 2'b11 : (r_ld_berr ? 2'b10 : 2'b00);
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
            rbeat_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (arready_q && S_ARVALID) begin
                        rid_q     <= S_ARID;
                        rlen_q    <= S_ARLEN;
                        rsize_q   <= S_ARSIZE;
                        rburst_q  <= S_ARBURST;
                        rberr_q   <= r_ld_berr;
                        rdata_q   <= rdata_d;
                        rresp_q   <= rresp_d;
                        rlast_q   <= (S_ARLEN == 4'd0);
                        rbeat_q   <= 4'd1;
                        raddr_q   <= next_addr(S_ARADDR, S_ARLEN, S_ARSIZE, S_ARBURST);
                        rvalid_q  <= 1'b1;
                        arready_q <= 1'b0;
                        r_state_q <= R_DATA;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (S_RREADY) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state_q <= R_IDLE;
                        end else begin
                            rdata_q <= rdata_d;
                            rresp_q <= rresp_d;
                            rlast_q <= (rbeat_q == rlen_q);
                            rbeat_q <= rbeat_q + 4'd1;
                            raddr_q <= next_addr(raddr_q, rlen_q, rsize_q, rburst_q);
                        end
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign S_AWREADY = awready_q;
    assign S_WREADY  = wready_q;
    assign S_BID     = bid_q;
    assign S_BRESP   = bresp_q;
    assign S_BVALID  = bvalid_q;
    assign S_ARREADY = arready_q;
    assign S_RID     = rid_q;
    assign S_RDATA   = rdata_q;
    assign S_RRESP   = rresp_q;
    assign S_RLAST   = rlast_q;
    assign S_RVALID  = rvalid_q;
endmodule
